maxpool_blk: RTL and testbench
==============================

MAXPOOL_BLK -- requirements
Module: maxpool_blk

Interface
REQ-001 SHALL have parameter IN_SIZE, default 250, giving the conv output map width and height in samples (252 - 3 + 1).
REQ-002 SHALL have parameter DATA_WIDTH, default 48, giving the signed sample width, equal to the conv_blk o_conv_result width.
REQ-003 SHALL have localparam POOL_SIZE = IN_SIZE / 2 (floor), giving the pooled map width and height.
REQ-004 i_clk  input  1  sole clock; all logic is on the rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_clear  input  1  synchronous frame restart; abandons the frame in progress.
REQ-007 i_en  input  1  input sample valid; connects to conv_blk o_en.
REQ-008 i_data  input  DATA_WIDTH  signed conv result; connects to conv_blk o_conv_result; raster order, row-major.
REQ-009 o_en  output  1  pooled sample valid, one-cycle pulse per sample.
REQ-010 o_data  output  DATA_WIDTH  signed pooled sample; raster order.
REQ-011 o_frame_done  output  1  one-cycle pulse when a frame's last input has been consumed.

Function
REQ-012 SHALL compute 2x2 max-pooling with stride 2 over each IN_SIZE x IN_SIZE frame, using signed comparison.
REQ-013 SHALL hold counters col (0..IN_SIZE-1) and row (0..IN_SIZE-1); both advance only on i_en=1.
- col wraps to 0 at IN_SIZE-1; row increments on that wrap.
- Both wrap to 0 after the last sample of a frame.
REQ-014 SHALL act as a state machine with states EVEN_ROW, ODD_ROW and DROP_ROW.
- Reset state is EVEN_ROW.
- EVEN_ROW -> ODD_ROW at the end of an even row.
- ODD_ROW -> EVEN_ROW at the end of an odd row, unless the next row is IN_SIZE-1 and IN_SIZE is odd; in that case -> DROP_ROW.
- DROP_ROW -> EVEN_ROW at the end of the frame.
REQ-015 In EVEN_ROW, for each accepted sample:
- Even col: latch hmax <= i_data.
- Odd col: write line buffer entry [col>>1] <= max(hmax, i_data).
REQ-016 In ODD_ROW, for each accepted sample:
- Even col: latch hmax <= i_data.
- Odd col: o_data <= max(lbuf[col>>1], hmax, i_data) and o_en <= 1, registered, one cycle after the accepting edge.
REQ-017 When IN_SIZE is odd, SHALL ignore all samples at col = IN_SIZE-1, and all samples in DROP_ROW, without any side effect except counter advance.
REQ-018 The line buffer SHALL hold POOL_SIZE entries of DATA_WIDTH bits; a read and a write of the same entry never occur in the same cycle.
REQ-019 SHALL pulse o_frame_done one cycle after the edge that accepts the sample at (row, col) = (IN_SIZE-1, IN_SIZE-1).
- When that sample also produces an output, o_en and o_frame_done assert in the same cycle.
REQ-020 SHALL produce exactly POOL_SIZE^2 o_en pulses per complete frame, with no back-pressure and a throughput of one input per cycle.
REQ-021 Gaps in i_en SHALL change no state and SHALL not affect results.
REQ-022 On an i_clear edge:
- col, row and hmax reset; state goes to EVEN_ROW.
- o_en and o_frame_done are 0 in the next cycle.
- The line buffer contents become don't-care.
- An i_en sample in the same cycle is discarded.
REQ-023 On equal compared values, either value is acceptable, since the results are identical.
REQ-024 Back-to-back frames SHALL be processed without an idle cycle.

Reset
REQ-025 While i_rst_n=0, the block SHALL hold o_en=0, o_data=0, o_frame_done=0, col=0, row=0, hmax=0 and state EVEN_ROW.
REQ-026 Reset assertion SHALL take effect asynchronously, mid-frame included; deassertion is synchronized externally to i_clk.
REQ-027 The line buffer SHALL not be reset.

Structure
REQ-028 The DATA_WIDTH default, the pooled-size function (n/2) and the state encoding SHALL live in shared package conv_pkg.
REQ-029 The line buffer SHALL be sub-module pool_line_buf: one write port, one asynchronous read port, parameterised by depth and width.

Verification
REQ-030 IN_SIZE=4, inputs 0..15 contiguous -> o_data sequence 5, 7, 13, 15; o_frame_done coincides with the o_en of value 15.
REQ-031 IN_SIZE=4, all inputs negative (-1 - k for k = 0..15) -> outputs -1, -3, -9, -11.
REQ-032 IN_SIZE=5, inputs 0..24 -> outputs 6, 8, 16, 18; column 4 and row 4 have no effect; o_frame_done follows input 24 with no o_en.
REQ-033 IN_SIZE=4, i_en toggled 1-0-1-0 across the frame -> same four outputs as REQ-030, each one cycle after its odd-column odd-row input.
REQ-034 IN_SIZE=4, i_clear asserted after input 9, then a full frame 100..115 -> outputs 105, 107, 113, 115 only.
REQ-035 IN_SIZE=4, two back-to-back frames 0..15 then 16..31, followed by i_rst_n pulsed low mid-third frame -> outputs 5, 7, 13, 15, 21, 23, 29, 31, then all outputs 0 during reset.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the conv/pool datapath: sample width,
// pooled-size helper and the pooling row-state encoding.
package conv_pkg;

  // Width of conv_blk o_conv_result, reused by the pooling stage.
  localparam int CONV_DATA_W = 48;

  // Row role inside a 2x2/stride-2 pooling window.
  typedef enum logic [1:0] {
    EVEN_ROW = 2'd0,
    ODD_ROW  = 2'd1,
    DROP_ROW = 2'd2
  } pool_state_e;

  // Pooled map dimension for an n-wide input (trailing odd sample dropped).
  function automatic int pool_size(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Single-write, asynchronous-read line buffer holding one row of
// horizontal pair maxima. Contents are intentionally not reset.
module pool_line_buf #(
  parameter int DEPTH  = 125,
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 7
) (
  input  logic                    i_clk,
  input  logic                    i_we,
  input  logic [ADDR_W-1:0]       i_waddr,
  input  logic signed [WIDTH-1:0] i_wdata,
  input  logic [ADDR_W-1:0]       i_raddr,
  output logic signed [WIDTH-1:0] o_rdata
);

  logic signed [WIDTH-1:0] mem_q [DEPTH];

  // Write one pair maximum per odd column of an even row.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/maxpool_blk.sv
// 2x2, stride-2 signed max-pooling over a raster-ordered square frame.
// Even rows fold column pairs into a line buffer; odd rows combine the
// buffered pair with the current pair and emit one pooled sample.
module maxpool_blk
  import conv_pkg::*;
#(
  parameter int IN_SIZE    = 250,
  parameter int DATA_WIDTH = CONV_DATA_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clear,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_en,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_frame_done
);

  localparam int POOL_SIZE = pool_size(IN_SIZE);
  localparam int CW        = (IN_SIZE > 2) ? $clog2(IN_SIZE) : 1;
  localparam int AW        = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam logic [CW-1:0] LAST     = CW'(IN_SIZE - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(IN_SIZE - 2);
  localparam bit   ODD_SIZE = (IN_SIZE % 2) == 1;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  pool_state_e                  state_q;
  logic [CW-1:0]                col_q, col_d;
  logic [CW-1:0]                row_q, row_d;
  logic signed [DATA_WIDTH-1:0] hmax_q;
  logic                         o_en_q;
  logic signed [DATA_WIDTH-1:0] o_data_q;
  logic                         done_q;

  logic                         accept;
  logic                         col_last, row_last;
  logic                         drop_col;
  logic                         active;
  logic                         pair_end;
  logic                         lb_we;
  logic [AW-1:0]                lb_addr;
  logic signed [DATA_WIDTH-1:0] lb_rdata;

  // A sample in the same cycle as i_clear is discarded.
  assign accept   = i_en && !i_clear;
  assign col_last = (col_q == LAST);
  assign row_last = (row_q == LAST);
  // On odd sizes the trailing column has no partner and is ignored.
  assign drop_col = ODD_SIZE && col_last;
  assign active   = accept && !drop_col && (state_q != DROP_ROW);
  assign pair_end = active && col_q[0];
  assign lb_we    = pair_end && (state_q == EVEN_ROW);
  assign lb_addr  = AW'(col_q >> 1);

  pool_line_buf #(
    .DEPTH  (POOL_SIZE),
    .WIDTH  (DATA_WIDTH),
    .ADDR_W (AW)
  ) u_line_buf (
    .i_clk   (i_clk),
    .i_we    (lb_we),
    .i_waddr (lb_addr),
    .i_wdata (smax(hmax_q, i_data)),
    .i_raddr (lb_addr),
    .o_rdata (lb_rdata)
  );

  // Raster position counters advance only on accepted samples.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Row-role FSM, counters, pair register and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= EVEN_ROW;
      col_q    <= '0;
      row_q    <= '0;
      hmax_q   <= '0;
      o_en_q   <= 1'b0;
      o_data_q <= '0;
      done_q   <= 1'b0;
    end else if (i_clear) begin
      state_q <= EVEN_ROW;
      col_q   <= '0;
      row_q   <= '0;
      hmax_q  <= '0;
      o_en_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      o_en_q <= pair_end && (state_q == ODD_ROW);
      done_q <= accept && col_last && row_last;
      if (pair_end && (state_q == ODD_ROW)) begin
        o_data_q <= smax(smax(lb_rdata, hmax_q), i_data);
      end
      if (active && !col_q[0]) begin
        hmax_q <= i_data;
      end
      if (accept && col_last) begin
        case (state_q)
          EVEN_ROW: state_q <= ODD_ROW;
          ODD_ROW:  state_q <= (ODD_SIZE && (row_q == PRE_LAST)) ? DROP_ROW : EVEN_ROW;
          DROP_ROW: state_q <= EVEN_ROW;
          default:  state_q <= EVEN_ROW;
        endcase
      end
    end
  end

  assign o_en         = o_en_q;
  assign o_data       = o_data_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_maxpool_blk.sv
// Directed bench for maxpool_blk with a 4x4 and a 5x5 instance.
module tb_maxpool_blk;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               en4, en5;
  logic signed [47:0] data;
  logic               oen4, oen5, done4, done5;
  logic signed [47:0] odata4, odata5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maxpool_blk #(.IN_SIZE(4), .DATA_WIDTH(48)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_en(en4), .i_data(data),
    .o_en(oen4), .o_data(odata4), .o_frame_done(done4)
  );

  maxpool_blk #(.IN_SIZE(5), .DATA_WIDTH(48)) dut5 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_en(en5), .i_data(data),
    .o_en(oen5), .o_data(odata5), .o_frame_done(done5)
  );

  task automatic chk(input string tag, input logic signed [47:0] obs,
                     input logic signed [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of input to the selected instance and check its result.
  task automatic step(input bit sel5, input logic e, input logic signed [47:0] v,
                      input logic exp_en, input logic signed [47:0] exp_d,
                      input logic exp_done, input string tag);
    data = v;
    if (sel5) en5 = e; else en4 = e;
    @(posedge clk); #1;
    en4 = 1'b0;
    en5 = 1'b0;
    chk({tag, "_en"}, sel5 ? oen5 : oen4, exp_en);
    chk({tag, "_done"}, sel5 ? done5 : done4, exp_done);
    if (exp_en) chk({tag, "_data"}, sel5 ? odata5 : odata4, exp_d);
  endtask

  // Contiguous increasing 4x4 frame: each window max is its bottom-right input.
  task automatic frame4(input int base, input string tag);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 48'(base + k), (k == 5 || k == 7 || k == 13 || k == 15),
           48'(base + k), (k == 15), tag);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; en4 = 1'b0; en5 = 1'b0; data = '0;
    #1;
    chk("rst_en4", oen4, 1'b0);
    chk("rst_data4", odata4, 48'sd0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_en5", oen5, 1'b0);
    chk("rst_data5", odata5, 48'sd0);
    chk("rst_done5", done5, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Inputs 0..15 -> 5, 7, 13, 15 with frame_done on the last.
    frame4(0, "inc");

    // All-negative frame -> -1, -3, -9, -11.
    for (int k = 0; k < 16; k++) begin
      logic signed [47:0] ev;
      case (k)
        5:       ev = -48'sd1;
        7:       ev = -48'sd3;
        13:      ev = -48'sd9;
        15:      ev = -48'sd11;
        default: ev = '0;
      endcase
      step(1'b0, 1'b1, 48'(-1 - k), (k == 5 || k == 7 || k == 13 || k == 15),
           ev, (k == 15), "neg");
    end

    // 5x5 frame: column 4 and row 4 ignored, done with no output.
    for (int k = 0; k < 25; k++) begin
      step(1'b1, 1'b1, 48'(k), (k == 6 || k == 8 || k == 16 || k == 18),
           48'(k), (k == 24), "odd5");
    end

    // Gaps between samples carry garbage data that must not be taken.
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b1, 48'(k), (k == 5 || k == 7 || k == 13 || k == 15),
           48'(k), (k == 15), "gap");
      step(1'b0, 1'b0, 48'sd999, 1'b0, '0, 1'b0, "gap_idle");
    end

    // Clear after input 9 abandons the frame; the clear-cycle sample is dropped.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 48'(k), (k == 5 || k == 7), 48'(k), 1'b0, "preclr");
    end
    clear = 1'b1;
    step(1'b0, 1'b1, 48'sd77, 1'b0, '0, 1'b0, "clr");
    clear = 1'b0;
    frame4(100, "postclr");

    // Back-to-back frames, then asynchronous reset mid-third-frame.
    frame4(0, "b2b_a");
    frame4(16, "b2b_b");
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, 48'(32 + k), (k == 5), 48'(32 + k), 1'b0, "third");
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", oen4, 1'b0);
    chk("arst_data", odata4, 48'sd0);
    chk("arst_done", done4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 48'sd50, 1'b0, '0, 1'b0, "inrst");
      chk("inrst_data", odata4, 48'sd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    frame4(0, "postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
